// File: rtl/cursor_ctrl.sv
// Board-cursor controller: decodes keyboard events into clamped cursor moves
// with hold-to-repeat, plus a one-cycle placement pulse on space.
module cursor_ctrl #(
    parameter int BOARD_N       = 15,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [10:0] key_event,
    input  logic        lock,
    output logic [3:0]  cursor_x,
    output logic [3:0]  cursor_y,
    output logic        is_pressed,
    output logic        moved,
    output logic        blocked
);

    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;

    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [3:0]       CENTER      = 4'((BOARD_N - 1) / 2);
    localparam logic [3:0]       EDGE_MAX    = 4'(BOARD_N - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Direction codes: Q W E A D Z X C
    localparam logic [2:0] DIR_Q = 3'd0;
    localparam logic [2:0] DIR_W = 3'd1;
    localparam logic [2:0] DIR_E = 3'd2;
    localparam logic [2:0] DIR_A = 3'd3;
    localparam logic [2:0] DIR_D = 3'd4;
    localparam logic [2:0] DIR_Z = 3'd5;
    localparam logic [2:0] DIR_X = 3'd6;
    localparam logic [2:0] DIR_C = 3'd7;

    logic [3:0]       x_q, x_d, y_q, y_d;
    logic             pressed_q, pressed_d;
    logic             moved_q, moved_d;
    logic             blocked_q, blocked_d;
    logic             prev_valid_q, prev_valid_d;
    logic [1:0]       state_q, state_d;
    logic [2:0]       held_dir_q, held_dir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic       key_dir_valid;
    logic [2:0] key_dir;
    logic       is_space;
    logic       new_ev, ev_ok;
    logic       held_active, dir_make, start_move, release_held, space_press, tick;
    logic       do_move;
    logic [2:0] mv_dir;
    logic       dx_neg, dx_pos, dy_neg, dy_pos;
    logic       move_ok;

    always_comb begin
        key_dir_valid = 1'b1;
        key_dir       = DIR_Q;
        case (key_event[7:0])
            8'h51, 8'h71: key_dir = DIR_Q;
            8'h57, 8'h77: key_dir = DIR_W;
            8'h45, 8'h65: key_dir = DIR_E;
            8'h41, 8'h61: key_dir = DIR_A;
            8'h44, 8'h64: key_dir = DIR_D;
            8'h5A, 8'h7A: key_dir = DIR_Z;
            8'h58, 8'h78: key_dir = DIR_X;
            8'h43, 8'h63: key_dir = DIR_C;
            default:      key_dir_valid = 1'b0;
        endcase
    end

    assign is_space     = (key_event[7:0] == 8'h20);
    assign new_ev       = key_event[10] & ~prev_valid_q;
    assign ev_ok        = new_ev & ~key_event[9];
    assign held_active  = (state_q != ST_IDLE);
    assign dir_make     = ev_ok & key_dir_valid & ~key_event[8];
    // Typematic re-makes of the held key are dropped; the internal timer owns repeats
    assign start_move   = dir_make & ~(held_active & (key_dir == held_dir_q));
    assign release_held = ev_ok & key_dir_valid & key_event[8] & held_active &
                          (key_dir == held_dir_q);
    assign space_press  = ev_ok & is_space & ~key_event[8];
    assign tick         = ((state_q == ST_DELAY)  && (cnt_q == DELAY_LAST)) ||
                          ((state_q == ST_REPEAT) && (cnt_q == PERIOD_LAST));

    // A fresh move or a release overrides a coincident repeat tick
    assign do_move = start_move | (tick & ~release_held);
    assign mv_dir  = start_move ? key_dir : held_dir_q;

    always_comb begin
        dx_neg = 1'b0;
        dx_pos = 1'b0;
        dy_neg = 1'b0;
        dy_pos = 1'b0;
        case (mv_dir)
            DIR_Q: begin dx_neg = 1'b1; dy_neg = 1'b1; end
            DIR_W: begin                dy_neg = 1'b1; end
            DIR_E: begin dx_pos = 1'b1; dy_neg = 1'b1; end
            DIR_A: begin dx_neg = 1'b1;                end
            DIR_D: begin dx_pos = 1'b1;                end
            DIR_Z: begin dx_neg = 1'b1; dy_pos = 1'b1; end
            DIR_X: begin                dy_pos = 1'b1; end
            default: begin dx_pos = 1'b1; dy_pos = 1'b1; end
        endcase
    end

    assign move_ok = !(dx_neg && (x_q == 4'd0))     && !(dx_pos && (x_q == EDGE_MAX)) &&
                     !(dy_neg && (y_q == 4'd0))     && !(dy_pos && (y_q == EDGE_MAX));

    always_comb begin
        x_d          = x_q;
        y_d          = y_q;
        pressed_d    = 1'b0;
        moved_d      = 1'b0;
        blocked_d    = 1'b0;
        prev_valid_d = key_event[10];
        state_d      = state_q;
        held_dir_d   = held_dir_q;
        cnt_d        = held_active ? (cnt_q + CNT_W'(1)) : '0;

        if (lock) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            pressed_d = space_press;
            if (do_move) begin
                cnt_d = '0;
                if (move_ok) begin
                    moved_d = 1'b1;
                    if (dx_neg) x_d = x_q - 4'd1;
                    if (dx_pos) x_d = x_q + 4'd1;
                    if (dy_neg) y_d = y_q - 4'd1;
                    if (dy_pos) y_d = y_q + 4'd1;
                end else begin
                    blocked_d = 1'b1;
                end
            end
            if (start_move) begin
                held_dir_d = key_dir;
                state_d    = ST_DELAY;
            end else if (release_held) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else if (tick && (state_q == ST_DELAY)) begin
                state_d = ST_REPEAT;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            x_q          <= CENTER;
            y_q          <= CENTER;
            pressed_q    <= 1'b0;
            moved_q      <= 1'b0;
            blocked_q    <= 1'b0;
            prev_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
            held_dir_q   <= DIR_Q;
            cnt_q        <= '0;
        end else begin
            x_q          <= x_d;
            y_q          <= y_d;
            pressed_q    <= pressed_d;
            moved_q      <= moved_d;
            blocked_q    <= blocked_d;
            prev_valid_q <= prev_valid_d;
            state_q      <= state_d;
            held_dir_q   <= held_dir_d;
            cnt_q        <= cnt_d;
        end
    end

    assign cursor_x   = x_q;
    assign cursor_y   = y_q;
    assign is_pressed = pressed_q;
    assign moved      = moved_q;
    assign blocked    = blocked_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Scoreboard bench for cursor_ctrl: a time-based reference model predicts every
// output pulse; a monitor matches DUT pulses against the expectation queue.
module tb_cursor_ctrl;

    localparam int N  = 15;
    localparam int RD = 8;
    localparam int RP = 4;
    localparam int CENTER = (N - 1) / 2;
    localparam logic [7:0] LET [8] = '{8'h51, 8'h57, 8'h45, 8'h41, 8'h44, 8'h5A, 8'h58, 8'h43};
    localparam int DXS [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    localparam int DYS [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [10:0] key_event = '0;
    logic        lock = 1'b0;
    logic [3:0]  cursor_x, cursor_y;
    logic        is_pressed, moved, blocked;

    cursor_ctrl #(.BOARD_N(N), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
        .clk(clk), .rstn(rstn), .key_event(key_event), .lock(lock),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .is_pressed(is_pressed), .moved(moved), .blocked(blocked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    typedef struct { int cyc; int val; } exp_t;
    exp_t expq[$];

    // Reference model: cursor position, held key and absolute time of next repeat
    int mx, my, held, next_rep;
    bit mprev;
    logic lk = 1'b0;

    function automatic int dir_of(input logic [7:0] c);
        logic [7:0] u;
        u = c;
        if (u >= 8'h61 && u <= 8'h7A) u = u - 8'h20;
        for (int i = 0; i < 8; i++) if (LET[i] == u) return i;
        return -1;
    endfunction

    function automatic int pack(input bit p, input bit m, input bit b, input int x, input int y);
        return (int'(p) << 10) | (int'(m) << 9) | (int'(b) << 8) | ((x & 15) << 4) | (y & 15);
    endfunction

    task automatic try_move(input int d, output bit mv, output bit bl);
        int nx, ny;
        nx = mx + DXS[d];
        ny = my + DYS[d];
        mv = 1'b0;
        bl = 1'b0;
        if (nx >= 0 && nx < N && ny >= 0 && ny < N) begin
            mx = nx;
            my = ny;
            mv = 1'b1;
        end else begin
            bl = 1'b1;
        end
    endtask

    task automatic model_reset();
        mx = CENTER; my = CENTER; held = -1; next_rep = 0; mprev = 1'b0;
    endtask

    task automatic model_edge(input logic [10:0] ev, input logic lkv, input int e);
        bit newev, took, p, mv, bl;
        int d;
        newev = ev[10] && !mprev;
        mprev = ev[10];
        took = 0; p = 0; mv = 0; bl = 0;
        d = dir_of(ev[7:0]);
        if (lkv) begin
            held = -1;
        end else begin
            if (newev && !ev[9]) begin
                if (d >= 0 && !ev[8] && d != held) begin
                    try_move(d, mv, bl);
                    held = d;
                    next_rep = e + RD;
                    took = 1;
                end else if (d >= 0 && ev[8] && d == held) begin
                    held = -1;
                    took = 1;
                end else if (ev[7:0] == 8'h20 && !ev[8]) begin
                    p = 1;
                end
            end
            if (!took && held >= 0 && e == next_rep) begin
                try_move(held, mv, bl);
                next_rep = e + RP;
            end
        end
        if (p || mv || bl) expq.push_back('{cyc: e, val: pack(p, mv, bl, mx, my)});
    endtask

    // Monitor: every edge either has an expected entry or must be pulse-free
    always @(negedge clk) begin
        int act;
        exp_t e;
        act = pack(is_pressed, moved, blocked, int'(cursor_x), int'(cursor_y));
        while (expq.size() > 0 && expq[0].cyc < cyc) begin
            e = expq.pop_front();
            chk("stale_expectation", e.cyc, cyc);
        end
        if (expq.size() > 0 && expq[0].cyc == cyc) begin
            e = expq.pop_front();
            chk("pulse", act, e.val);
        end else if (is_pressed || moved || blocked) begin
            chk("unexpected_pulse", act & 32'h700, 0);
        end
    end

    task automatic step(input logic [10:0] ev);
        @(negedge clk);
        key_event = ev;
        lock = lk;
        model_edge(ev, lk, cyc + 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(11'd0);
    endtask

    task automatic send(input logic [7:0] c, input logic brk, input logic ext);
        step({1'b1, ext, brk, c});
        step(11'd0);
    endtask

    task automatic press(input logic [7:0] c);
        send(c, 1'b0, 1'b0);
        send(c, 1'b1, 1'b0);
    endtask

    task automatic check_pos(input string name, input int ex, input int ey);
        chk({name, "_x"}, int'(cursor_x), ex);
        chk({name, "_y"}, int'(cursor_y), ey);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rstn = 1'b0;
        key_event = '0;
        #1;
        check_pos("async_reset", CENTER, CENTER);
        chk("async_reset_pulses", int'({is_pressed, moved, blocked}), 0);
        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        logic [7:0] c;
        logic brk, ext;

        model_reset();
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        #1;
        check_pos("reset", 7, 7);
        chk("reset_pulses", int'({is_pressed, moved, blocked}), 0);

        // Move and press
        send(8'h64, 1'b0, 1'b0);
        send(8'h77, 1'b0, 1'b0);
        send(8'h20, 1'b0, 1'b0);
        send(8'h20, 1'b1, 1'b0);
        send(8'h77, 1'b1, 1'b0);
        send(8'h64, 1'b1, 1'b0);
        idle(4);
        check_pos("move_press", 8, 6);

        // Edge blocking from the corner
        repeat (6) press(8'h71);
        repeat (2) press(8'h61);
        check_pos("corner", 0, 0);
        press(8'h71);
        press(8'h61);
        press(8'h65);
        check_pos("blocked", 0, 0);
        press(8'h63);
        check_pos("diag", 1, 1);

        // Hold-to-repeat up to the right edge
        repeat (6) press(8'h63);
        check_pos("recentre", 7, 7);
        send(8'h44, 1'b0, 1'b0);
        idle(40);
        send(8'h64, 1'b1, 1'b0);
        idle(10);
        check_pos("hold_repeat", 14, 7);

        // Key switch while held, including coincident event/tick edges
        send(8'h78, 1'b0, 1'b0);
        idle(14);
        send(8'h61, 1'b0, 1'b0);
        idle(10);
        send(8'h58, 1'b1, 1'b0);
        idle(6);
        send(8'h61, 1'b1, 1'b0);
        idle(10);
        check_pos("key_switch", 10, 10);

        // Lock during a held key and a space make
        send(8'h64, 1'b0, 1'b0);
        idle(3);
        lk = 1'b1;
        idle(2);
        send(8'h20, 1'b0, 1'b0);
        idle(20);
        lk = 1'b0;
        idle(20);
        check_pos("lock", 11, 10);
        send(8'h64, 1'b0, 1'b1);
        idle(12);
        check_pos("extended_ignored", 11, 10);
        send(8'h64, 1'b1, 1'b0);

        // Reset while repeating, right after a move pulse
        send(8'h77, 1'b0, 1'b0);
        idle(15);
        do_reset();
        idle(20);
        check_pos("after_reset", 7, 7);

        // Randomised traffic
        for (int it = 0; it < 160; it++) begin
            r = $urandom_range(0, 11);
            if (r < 8) c = LET[r] | (($urandom_range(0, 1) == 1) ? 8'h20 : 8'h00);
            else if (r < 10) c = 8'h20;
            else c = 8'h6D;
            brk = ($urandom_range(0, 2) == 0);
            ext = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 24) == 0) lk = ~lk;
            repeat ($urandom_range(1, 2)) step({1'b1, ext, brk, c});
            idle($urandom_range(1, 12));
        end
        lk = 1'b1;
        idle(2);
        lk = 1'b0;
        idle(5);
        check_pos("random_final", mx, my);

        idle(3);
        @(negedge clk);
        #1;
        chk("queue_drained", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
